stack_tos: RTL and testbench
============================

// Module: stack_tos
// PURPOSE
//  Next-generation hardware stack for the Sapho core (data or subroutine stack).
//  Top-of-stack (TOS) and next-on-stack (NOS) are held in registers, and deeper entries live in a sync-read RAM.
//  One push, pop or replace per clock, back to back, with 1-cycle latency.
//  Adds occupancy count, full/empty flags, sticky overflow/underflow flags, flush, and an optional circular (wrap) mode.
// PARAMETERS
//  NBITS = 32  data width
//  DEPTH = 16  total entries incl. TOS; minimum 3
//  NADDR = $clog2(DEPTH)  RAM address width; RAM holds DEPTH-1 entries
//  WRAP  = 0   0: push when full is dropped; 1: push when full discards the oldest entry
// PORTS
//  clk      in   1          clock
//  rst      in   1          synchronous reset, active high
//  push     in   1          push din
//  pop      in   1          pop TOS
//  din      in   NBITS      data to push
//  flush    in   1          empty the stack; has priority over push/pop
//  clr_err  in   1          clear ovf/unf
//  tos      out  NBITS      current top of stack (registered)
//  nos      out  NBITS      entry below TOS (registered)
//  count    out  NADDR+1    occupancy, range 0..DEPTH
//  empty    out  1          count==0
//  full     out  1          count==DEPTH
//  ovf      out  1          sticky: a push was attempted while full
//  unf      out  1          sticky: a pop or replace was attempted while empty
// BEHAVIOUR
//  Reset (rst=1 at posedge), all state:
//   - tos=0, nos=0, count=0, empty=1, full=0, ovf=0, unf=0, write ptr wp=0.
//   - RAM contents are unspecified.
//  Priority order: rst > flush > op.
//   - flush: count<=0, wp<=0; tos/nos keep their values; ovf/unf unchanged.
//  Operations, all sampled at posedge; results are visible on the same edge:
//   - PUSH (push & ~pop, not full):
//     RAM[wp]<=tos; nos<=tos; tos<=din; wp<=wp+1; count++.
//   - POP (pop & ~push, count>=1):
//     tos<=nos; nos<=RAM[wp-2]; wp<=wp-1; count--.
//     When count<=2, nos becomes a don't-care.
//   - REPLACE (push & pop, count>=1): tos<=din; nos, wp and count unchanged.
//   - PUSH when full, WRAP=0: no state change; ovf<=1.
//   - PUSH when full, WRAP=1: performed as PUSH, but count stays DEPTH; the oldest entry is overwritten; ovf<=1.
//   - POP or REPLACE when empty: no state change; unf<=1.
//  NOS refill: the RAM read port is always addressed at wp_next-1.
//   - A same-cycle write to that address is bypassed (write-first).
//   - Therefore nos equals the entry below TOS every cycle.
//  Pointer arithmetic: wp and all RAM addresses are modulo (DEPTH-1), using an explicit compare-and-wrap (not power-of-2 rollover).
//  clr_err clears ovf/unf. An error occurring in the same cycle wins, so the flag stays 1.
//  rst in the middle of an operation sequence: the stack returns to empty with no residual effect.
//  Pops after an overflow with WRAP=0 return the entries that existed before the dropped push.
//  Combinational outputs: empty and full are decoded from count. There is no combinational path from inputs to outputs.
// STRUCTURE
//  Shared include core_defs.vh:
//   - stack op encodings (OP_NONE/PUSH/POP/REPL) used by instr_dec and core;
//   - the function clog2_min1.
//  Sub-module stack_ram:
//   - DEPTH-1 x NBITS, 1 write port and 1 sync read port;
//   - write-first bypass inside;
//   - infers block RAM.
//  Top level holds: the op decode, the tos/nos registers, count/wp logic, the wrap compare and the error flags.
// TESTING
//  Push 1..5 (DEPTH=16):
//   -> tos=5, nos=4, count=5.
//   -> then 5 pops yield tos 4,3,2,1 in turn, then count=0, empty=1, unf=0.
//  Alternate push A / pop every cycle for 100 cycles:
//   -> count toggles 1/0; tos=A after each push; no flags.
//  Fill 16 (WRAP=0), then push 99:
//   -> full=1, ovf=1, tos=16.
//   -> 16 pops return 16..1.
//  WRAP=1, push 1..20:
//   -> count=16, ovf=1.
//   -> pops return 20..5, then empty.
//  Push 7, then push&pop with din=9 on an empty-plus-one stack:
//   -> tos=9, count=1.
//   -> push&pop on an empty stack: unf=1, count=0.
//  Push 3 values, assert flush and clr_err together with pop, then rst mid-sequence:
//   -> count=0 after flush; ovf=unf=0.
//   -> after rst, all outputs hold their reset values.

Source files
------------

// File: rtl/stack_tos_pkg.sv
// Shared definitions for the Sapho register-cached hardware stack.
// Stack op encodings and a minimum-1 clog2 helper.
package stack_tos_pkg;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPL
  } stack_op_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stack_tos_ram.sv
// Backing store for stack entries below TOS.
// One write port, one sync read port with write-first bypass.
module stack_tos_ram #(
  parameter int NBITS  = 32,
  parameter int NADDR  = 4,
  parameter int NWORDS = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [NADDR-1:0] waddr,
  input  logic [NBITS-1:0] wdata,
  input  logic             re,
  input  logic [NADDR-1:0] raddr,
  output logic [NBITS-1:0] rdata
);

  logic [NBITS-1:0] mem [NWORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register doubles as the NOS register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      if (we && (waddr == raddr)) rdata <= wdata;
      else rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/stack_tos.sv
// Hardware stack with TOS/NOS in registers, deeper entries in RAM.
// One push/pop/replace per clock; optional circular overwrite when full.
module stack_tos
  import stack_tos_pkg::*;
#(
  parameter int NBITS = 32,
  parameter int DEPTH = 16,
  parameter int NADDR = clog2_min1(DEPTH),
  parameter int WRAP  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [NBITS-1:0] din,
  input  logic             flush,
  input  logic             clr_err,
  output logic [NBITS-1:0] tos,
  output logic [NBITS-1:0] nos,
  output logic [NADDR:0]   count,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam int NWORDS = DEPTH - 1;
  localparam logic [NADDR-1:0] LAST = NADDR'(NWORDS - 1);
  localparam logic [NADDR:0] FULL_CNT = (NADDR + 1)'(DEPTH);
  localparam bit WRAP_EN = (WRAP != 0);

  function automatic logic [NADDR-1:0] wp_inc(
    input logic [NADDR-1:0] a
  );
    return (a == LAST) ? '0 : a + NADDR'(1);
  endfunction

  function automatic logic [NADDR-1:0] wp_dec(
    input logic [NADDR-1:0] a
  );
    return (a == '0) ? LAST : a - NADDR'(1);
  endfunction

  stack_op_e        op;
  logic [NADDR-1:0] wp;
  logic [NADDR-1:0] wp_next;
  logic [NADDR:0]   count_next;
  logic [NBITS-1:0] tos_next;
  logic             do_push;
  logic             do_pop;
  logic             do_repl;
  logic             ovf_set;
  logic             unf_set;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  always_comb begin
    op = OP_NONE;
    unique case (1'b1)
      push && pop:  op = OP_REPL;
      push && !pop: op = OP_PUSH;
      pop && !push: op = OP_POP;
      default:      op = OP_NONE;
    endcase
  end

  always_comb begin
    do_push = !flush && (op == OP_PUSH) && (!full || WRAP_EN);
    do_pop  = !flush && (op == OP_POP) && !empty;
    do_repl = !flush && (op == OP_REPL) && !empty;
    ovf_set = !flush && (op == OP_PUSH) && full;
    unf_set = !flush && ((op == OP_POP) || (op == OP_REPL)) && empty;
  end

  always_comb begin
    wp_next    = wp;
    count_next = count;
    tos_next   = tos;
    if (flush) begin
      wp_next    = '0;
      count_next = '0;
    end else if (do_push) begin
      wp_next  = wp_inc(wp);
      tos_next = din;
      if (!full) count_next = count + (NADDR + 1)'(1);
    end else if (do_pop) begin
      wp_next    = wp_dec(wp);
      tos_next   = nos;
      count_next = count - (NADDR + 1)'(1);
    end else if (do_repl) begin
      tos_next = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      count <= '0;
      tos   <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      wp    <= wp_next;
      count <= count_next;
      tos   <= tos_next;
      ovf   <= ovf_set | (ovf & ~clr_err);
      unf   <= unf_set | (unf & ~clr_err);
    end
  end

  // Read address tracks the entry that will sit below the new TOS.
  stack_tos_ram #(
    .NBITS (NBITS),
    .NADDR (NADDR),
    .NWORDS(NWORDS)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (do_push),
    .waddr(wp),
    .wdata(tos),
    .re   (do_push | do_pop),
    .raddr(wp_dec(wp_next)),
    .rdata(nos)
  );

endmodule

// File: tb/tb_stack_tos.sv
// Bench for stack_tos: WRAP=0 and WRAP=1 instances on shared stimulus.
// Vector table, directed corner sequences and random traffic vs a model.
module tb_stack_tos;

  localparam int NB = 32;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          flush = 1'b0;
  logic          clr_err = 1'b0;
  logic [NB-1:0] din = '0;

  logic [NB-1:0] tos0, nos0, tos1, nos1;
  logic [4:0]    count0, count1;
  logic          empty0, full0, ovf0, unf0;
  logic          empty1, full1, ovf1, unf1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stack_tos #(.NBITS(NB), .DEPTH(DP), .WRAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .flush(flush), .clr_err(clr_err), .tos(tos0), .nos(nos0),
    .count(count0), .empty(empty0), .full(full0),
    .ovf(ovf0), .unf(unf0)
  );

  stack_tos #(.NBITS(NB), .DEPTH(DP), .WRAP(1)) u_dut1 (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din),
    .flush(flush), .clr_err(clr_err), .tos(tos1), .nos(nos1),
    .count(count1), .empty(empty1), .full(full1),
    .ovf(ovf1), .unf(unf1)
  );

  // Reference: a plain array stack, index 0 = oldest.
  logic [NB-1:0] m_stk [2][DP];
  int            m_cnt [2];
  bit            m_ovf [2];
  bit            m_unf [2];

  typedef struct {
    bit            p;
    bit            q;
    bit            f;
    bit            c;
    logic [NB-1:0] d;
    int            cnt;
    logic [NB-1:0] tos;
    bit            ovf;
    bit            unf;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string name, input logic [NB-1:0] act,
                     input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_ovf[k] = 0;
      m_unf[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    bit os, us;
    os = 0;
    us = 0;
    if (!flush) begin
      if (push && !pop) begin
        if (m_cnt[k] == DP) begin
          os = 1;
          if (k == 1) begin
            for (int i = 0; i < DP - 1; i++) m_stk[k][i] = m_stk[k][i+1];
            m_stk[k][DP-1] = din;
          end
        end else begin
          m_stk[k][m_cnt[k]] = din;
          m_cnt[k]++;
        end
      end else if (pop && !push) begin
        if (m_cnt[k] == 0) us = 1;
        else m_cnt[k]--;
      end else if (push && pop) begin
        if (m_cnt[k] == 0) us = 1;
        else m_stk[k][m_cnt[k]-1] = din;
      end
    end else begin
      m_cnt[k] = 0;
    end
    m_ovf[k] = os || (m_ovf[k] && !clr_err);
    m_unf[k] = us || (m_unf[k] && !clr_err);
  endtask

  task automatic check_model(input int k);
    logic [NB-1:0] t, n;
    logic [4:0]    c;
    logic          e, fl, o, u;
    t = k ? tos1 : tos0;
    n = k ? nos1 : nos0;
    c = k ? count1 : count0;
    e = k ? empty1 : empty0;
    fl = k ? full1 : full0;
    o = k ? ovf1 : ovf0;
    u = k ? unf1 : unf0;
    chk($sformatf("m%0d.count", k), 32'(c), m_cnt[k]);
    chk($sformatf("m%0d.empty", k), 32'(e), 32'(m_cnt[k] == 0));
    chk($sformatf("m%0d.full", k), 32'(fl), 32'(m_cnt[k] == DP));
    chk($sformatf("m%0d.ovf", k), 32'(o), 32'(m_ovf[k]));
    chk($sformatf("m%0d.unf", k), 32'(u), 32'(m_unf[k]));
    if (m_cnt[k] >= 1)
      chk($sformatf("m%0d.tos", k), t, m_stk[k][m_cnt[k]-1]);
    if (m_cnt[k] >= 2)
      chk($sformatf("m%0d.nos", k), n, m_stk[k][m_cnt[k]-2]);
  endtask

  task automatic cyc(input bit p, input bit q, input logic [NB-1:0] d,
                     input bit f = 0, input bit c = 0);
    push = p;
    pop = q;
    din = d;
    flush = f;
    clr_err = c;
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_model(0);
    check_model(1);
    push = 0;
    pop = 0;
    flush = 0;
    clr_err = 0;
  endtask

  task automatic rst_cyc(input bit p = 0);
    rst = 1;
    push = p;
    din = 32'hdead;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 0;
    push = 0;
    chk("rst.tos0", tos0, 0);
    chk("rst.nos0", nos0, 0);
    chk("rst.tos1", tos1, 0);
    chk("rst.nos1", nos1, 0);
    check_model(0);
    check_model(1);
  endtask

  initial begin
    logic [NB-1:0] a;

    vt[0]  = '{1, 0, 0, 0, 1, 1, 1, 0, 0};
    vt[1]  = '{1, 0, 0, 0, 2, 2, 2, 0, 0};
    vt[2]  = '{1, 0, 0, 0, 3, 3, 3, 0, 0};
    vt[3]  = '{1, 1, 0, 0, 9, 3, 9, 0, 0};
    vt[4]  = '{0, 1, 0, 0, 0, 2, 2, 0, 0};
    vt[5]  = '{0, 1, 0, 0, 0, 1, 1, 0, 0};
    vt[6]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[7]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
    vt[8]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
    vt[9]  = '{1, 0, 0, 0, 7, 1, 7, 0, 0};
    vt[10] = '{1, 1, 0, 0, 9, 1, 9, 0, 0};
    vt[11] = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[12] = '{1, 1, 0, 0, 5, 0, 0, 0, 1};
    vt[13] = '{1, 0, 0, 1, 4, 1, 4, 0, 0};
    vt[14] = '{1, 0, 1, 0, 6, 0, 0, 0, 0};
    vt[15] = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
    vt[16] = '{0, 1, 0, 1, 0, 0, 0, 0, 1};
    vt[17] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};

    model_reset();
    rst_cyc();
    chk("reset.count0", 32'(count0), 0);
    chk("reset.empty0", 32'(empty0), 1);
    chk("reset.full0", 32'(full0), 0);

    // Push 1..5 then pop down to empty.
    for (int i = 1; i <= 5; i++) cyc(1, 0, i);
    chk("p5.tos", tos0, 5);
    chk("p5.nos", nos0, 4);
    chk("p5.count", 32'(count0), 5);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 1, 0);
      if (i < 5) chk("p5.pop.tos", tos0, 5 - i);
    end
    chk("p5.end.count", 32'(count0), 0);
    chk("p5.end.empty", 32'(empty0), 1);
    chk("p5.end.unf", 32'(unf0), 0);

    // Alternating push/pop.
    for (int i = 0; i < 50; i++) begin
      a = $urandom;
      cyc(1, 0, a);
      chk("alt.tos", tos0, a);
      chk("alt.count1", 32'(count0), 1);
      cyc(0, 1, 0);
      chk("alt.count0", 32'(count0), 0);
    end
    chk("alt.flags", 32'({ovf0, unf0}), 0);

    // Fill then overflow.
    rst_cyc();
    for (int i = 1; i <= 16; i++) cyc(1, 0, i);
    cyc(1, 0, 99);
    chk("ovf.full", 32'(full0), 1);
    chk("ovf.ovf", 32'(ovf0), 1);
    chk("ovf.tos", tos0, 16);
    chk("ovfw.tos", tos1, 99);
    chk("ovfw.count", 32'(count1), 16);
    for (int i = 0; i < 16; i++) begin
      chk("ovf.pop.tos", tos0, 16 - i);
      cyc(0, 1, 0);
    end
    chk("ovf.empty", 32'(empty0), 1);

    // Circular mode: push 1..20.
    rst_cyc();
    for (int i = 1; i <= 20; i++) cyc(1, 0, i);
    chk("wrap.count", 32'(count1), 16);
    chk("wrap.ovf", 32'(ovf1), 1);
    for (int i = 0; i < 16; i++) begin
      chk("wrap.pop.tos", tos1, 20 - i);
      cyc(0, 1, 0);
    end
    chk("wrap.empty", 32'(empty1), 1);

    // Vector table on the non-wrapping instance.
    rst_cyc();
    foreach (vt[i]) begin
      cyc(vt[i].p, vt[i].q, vt[i].d, vt[i].f, vt[i].c);
      chk($sformatf("vec%0d.count", i), 32'(count0), vt[i].cnt);
      chk($sformatf("vec%0d.ovf", i), 32'(ovf0), 32'(vt[i].ovf));
      chk($sformatf("vec%0d.unf", i), 32'(unf0), 32'(vt[i].unf));
      if (vt[i].cnt > 0)
        chk($sformatf("vec%0d.tos", i), tos0, vt[i].tos);
    end

    // Flush with clr_err and pop, then reset mid-sequence.
    rst_cyc();
    cyc(0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 32'h100 + i);
    cyc(0, 1, 0, 1, 1);
    chk("flush.count", 32'(count0), 0);
    chk("flush.ovf", 32'(ovf0), 0);
    chk("flush.unf", 32'(unf0), 0);
    cyc(1, 0, 32'h55);
    cyc(1, 0, 32'h66);
    rst_cyc(1);
    chk("midrst.count", 32'(count0), 0);
    chk("midrst.empty", 32'(empty0), 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_cyc($urandom_range(0, 1) == 1);
      end else begin
        cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
            $urandom, $urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 5);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
